// File: rtl/mux8way_if.sv
// Eight-channel gather bus: per-channel valid/ready/data in, one registered stream out.
// The in_last signal exists only when MUX8WAY_PKT_LOCK_EN is defined.
interface mux8way_if #(
  parameter int unsigned WIDTH = 8
);
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;
`ifdef MUX8WAY_PKT_LOCK_EN
  logic [7:0]         in_last;
`endif

`ifdef MUX8WAY_PKT_LOCK_EN
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
`endif
endinterface

// File: rtl/mux8way_rr_arbiter.sv
// Round-robin 8:1 gathering mux with a single registered output stage.
// Define MUX8WAY_PKT_LOCK_EN to hold the grant on one channel until in_last.
module mux8way_rr_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  mux8way_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} ostate_e;

  ostate_e          ostate_q, ostate_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;

`ifdef MUX8WAY_PKT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lstate_e;

  lstate_e          lock_q, lock_d;
  logic [2:0]       lock_idx_q, lock_idx_d;
`endif

  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       load;
  logic       xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ostate_q   <= EMPTY;
      data_q     <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
`ifdef MUX8WAY_PKT_LOCK_EN
      lock_q     <= UNLOCKED;
      lock_idx_q <= '0;
`endif
    end else begin
      ostate_q   <= ostate_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef MUX8WAY_PKT_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  // Scan from rr_ptr upward; a held packet masks every other requester.
  always_comb begin
    req = bus.in_valid;
`ifdef MUX8WAY_PKT_LOCK_EN
    if (lock_q == LOCKED) req = bus.in_valid & (8'b1 << lock_idx_q);
`endif
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = rr_ptr_q + 3'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    load  = (ostate_q == EMPTY) || bus.out_ready;
    grant = (found && load && rst_n) ? (8'b1 << win) : '0;
    xfer  = |grant;
  end

  always_comb begin
    ostate_d   = ostate_q;
    data_d     = data_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
`ifdef MUX8WAY_PKT_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    if (load) begin
      if (xfer) begin
        ostate_d = FULL;
        data_d   = bus.in_data[win*WIDTH +: WIDTH];
        sel_d    = win;
        rr_ptr_d = win + 3'd1;
`ifdef MUX8WAY_PKT_LOCK_EN
        lock_d     = bus.in_last[win] ? UNLOCKED : LOCKED;
        lock_idx_d = win;
`endif
      end else begin
        ostate_d = EMPTY;
      end
    end
  end

  always_comb begin
    bus.in_ready  = grant;
    bus.out_valid = (ostate_q == FULL);
    bus.out_data  = data_q;
    bus.out_sel   = sel_q;
  end

endmodule
